// File: rtl/fns_enc_38.sv
// Sequential Fibonacci-numeral-system encoder: greedy MSB-first weight subtraction,
// one code bit per clock, valid/ready on both sides.
module fns_enc_38 #(
  parameter int N_BITS = 38,
  parameter int DATA_W = 27
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] datain,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] codeout,
  output logic              out_err
);
  localparam int KW = $clog2(N_BITS);

  // W_0 = W_1 = 1, W_k = W_(k-1) + W_(k-2)
  function automatic longint unsigned wgt(input int k);
    longint unsigned a, b, t;
    a = 1;
    b = 1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic longint unsigned wsum(input int n);
    longint unsigned s;
    s = 0;
    for (int i = 0; i < n; i++) s += wgt(i);
    return s;
  endfunction

  localparam logic [DATA_W-1:0] MAXVAL = DATA_W'(wsum(N_BITS));
  localparam logic [DATA_W-1:0] W_HI   = DATA_W'(wgt(N_BITS-1));
  localparam logic [DATA_W-1:0] W_LO   = DATA_W'(wgt(N_BITS-2));

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] rem, wa, wb;
  logic [KW-1:0]     k;
  logic              err;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_err   = err & (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Out-of-range words still spend one RUN cycle so their result appears one
  // edge after accept; the err flag suppresses all bit updates there.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (err || k == KW'(0)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      wa      <= '0;
      wb      <= '0;
      k       <= '0;
      err     <= 1'b0;
      codeout <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          rem     <= datain;
          codeout <= '0;
          k       <= KW'(N_BITS-1);
          wa      <= W_HI;
          wb      <= W_LO;
          err     <= (datain > MAXVAL);
        end
        RUN: begin
          if (!err) begin
            if (rem >= wa) begin
              codeout[k] <= 1'b1;
              rem        <= rem - wa;
            end
            if (k == KW'(0))
              assert ((rem >= wa ? rem - wa : rem) == '0);
          end
          // weight pair steps down: (W_k, W_(k-1)) -> (W_(k-1), W_(k-2))
          wa <= wb;
          wb <= wa - wb;
          k  <= k - KW'(1);
        end
        DONE: if (out_ready) err <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fns_enc_38.sv
// Directed + random scoreboard bench for fns_enc_38; results are decoded back
// with an independent Fibonacci-weight sum.
module tb_fns_enc_38;
  localparam int N_BITS = 38;
  localparam int DATA_W = 27;
  localparam longint unsigned MAXVAL = 64'd102334154;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] datain = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [N_BITS-1:0] codeout;
  logic              out_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    longint unsigned data;
    logic            err;
    int              lat;
    logic            has_code;
    logic [N_BITS-1:0] code;
  } exp_t;
  exp_t sb[$];

  fns_enc_38 #(.N_BITS(N_BITS), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .datain(datain), .out_valid(out_valid), .out_ready(out_ready),
    .codeout(codeout), .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned fdec(input logic [N_BITS-1:0] c);
    longint unsigned a, b, t, s;
    a = 1; b = 1; s = 0;
    for (int i = 0; i < N_BITS; i++) begin
      if (c[i]) s += a;
      t = a + b; a = b; b = t;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // drive one word and push its expectation; returns after the accept edge
  task automatic send(input longint unsigned d, input logic has_code, input logic [N_BITS-1:0] code);
    exp_t e;
    int n;
    n = 0;
    in_valid = 1'b1;
    datain = DATA_W'(d);
    while (!in_ready && n < 200) begin tick(); n++; end
    chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    e.data = d;
    e.err = (d > MAXVAL);
    e.lat = e.err ? 1 : N_BITS;
    e.has_code = has_code | e.err;
    e.code = e.err ? '0 : code;
    sb.push_back(e);
  endtask

  // wait for the result (called right after send), compare, then hand off
  task automatic recv(input int stall);
    exp_t e;
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 200) begin tick(); cyc++; end
    e = sb.pop_front();
    chk("latency", 64'(cyc), 64'(e.lat));
    chk("out_err", {63'd0, out_err}, {63'd0, e.err});
    if (e.has_code) chk("codeout", 64'(codeout), 64'(e.code));
    else            chk("decode", 64'(fdec(codeout)), 64'(e.data));
    repeat (stall) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("handoff_valid", {63'd0, out_valid}, 64'd0);
    chk("handoff_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [N_BITS-1:0] hold_code;
    logic stable;
    #12;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_codeout", 64'(codeout), 64'd0);
    chk("rst_out_err", {63'd0, out_err}, 64'd0);
    rst_n = 1'b1;
    tick();

    // reset in the middle of RUN discards the word
    send(500, 1'b0, '0);
    repeat (9) @(posedge clk);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_valid", {63'd0, out_valid}, 64'd0);
    chk("midrun_code", 64'(codeout), 64'd0);
    chk("midrun_ready", {63'd0, in_ready}, 64'd1);
    void'(sb.pop_front());
    tick();
    rst_n = 1'b1;
    tick();
    send(500, 1'b0, '0); recv(0);

    // corners and range limits
    send(0, 1'b1, 38'h0);            recv(0);
    send(1, 1'b1, 38'h2);            recv(1);
    send(2, 1'b1, 38'h4);            recv(0);
    send(4, 1'b1, 38'hA);            recv(2);
    send(MAXVAL, 1'b1, 38'h3F_FFFF_FFFF); recv(0);
    send(MAXVAL + 1, 1'b1, '0);      recv(0);
    send(134217727, 1'b1, '0);       recv(1);

    // backpressure: result held for 20 cycles
    send(12345, 1'b0, '0);
    begin
      int cyc;
      cyc = 0;
      while (!out_valid && cyc < 200) begin tick(); cyc++; end
      chk("bp_latency", 64'(cyc), 64'(N_BITS));
    end
    hold_code = codeout;
    stable = 1'b1;
    in_valid = 1'b1;
    datain = DATA_W'(7);
    repeat (20) begin
      tick();
      if (!out_valid || in_ready || codeout !== hold_code) stable = 1'b0;
    end
    in_valid = 1'b0;
    chk("bp_stable", {63'd0, stable}, 64'd1);
    chk("bp_decode", 64'(fdec(codeout)), 64'd12345);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle", {63'd0, in_ready}, 64'd1);
    void'(sb.pop_front());

    // random round trip with random gaps and stalls
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(longint'($urandom_range(0, 102334154)), 1'b0, '0);
      recv($urandom_range(0, 3));
    end
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
